// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared types and constants for the instruction memory loader
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } ldr_state_t;

  // All-zero instruction word; sliced down to the instance WIDTH.
  localparam logic [63:0] NOP = 64'h0;

endpackage

// File: rtl/instr_mem_loader_ram.sv
// rtl/instr_mem_loader_ram.sv - simple dual-port program RAM, registered read, read-before-write
module imem_sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-edge read of the written index sees the old word.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - program loader FSM with a 1-cycle instruction fetch port
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_start,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_overflow,
  output logic             run,
  input  logic             fetch_req,
  input  logic [WIDTH-1:0] fetch_pc,
  input  logic             stall,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] fetch_instr,
  output logic             fetch_fault
);

  localparam logic [WIDTH-1:0] NOP_W = NOP[WIDTH-1:0];
  localparam logic [AW:0]      ONE   = {{AW{1'b0}}, 1'b1};

  ldr_state_t state, state_nxt;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      prog_len;
  logic [AW:0]      wr_idx;
  logic             accept;
  logic             in_range;
  logic             mem_we;

  logic [AW-1:0]    fetch_idx;
  logic             misaligned;
  logic             hi_bits;
  logic             out_of_range;
  logic             fault_nxt;
  logic             rd_en;
  logic             valid_q;
  logic             fault_q;
  logic [WIDTH-1:0] ram_rdata;

  // A start pulse accepts its own word at index 0 even before the FSM reaches LOAD.
  assign accept   = ld_valid && (ld_ready || ld_start);
  assign wr_idx   = ld_start ? '0 : wr_ptr;
  assign in_range = ~wr_idx[AW];
  assign mem_we   = accept && in_range;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ld_start) begin
      state_nxt = (accept && ld_last) ? ST_RUN : ST_LOAD;
    end else if (state == ST_LOAD && accept && ld_last) begin
      state_nxt = ST_RUN;
    end
  end

  always_comb begin
    ld_ready = 1'b0;
    if (state == ST_LOAD) begin
      ld_ready = 1'b1;
    end
  end

  // The pointer saturates at DEPTH; further words are dropped and flagged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      prog_len    <= '0;
      ld_overflow <= 1'b0;
    end else if (ld_start) begin
      wr_ptr      <= mem_we ? ONE : '0;
      prog_len    <= mem_we ? ONE : '0;
      ld_overflow <= 1'b0;
    end else if (accept) begin
      if (in_range) begin
        wr_ptr   <= wr_ptr + ONE;
        prog_len <= wr_ptr + ONE;
      end else begin
        ld_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run <= 1'b0;
    end else begin
      run <= (state == ST_RUN);
    end
  end

  assign fetch_idx    = fetch_pc[AW+1:2];
  assign misaligned   = |fetch_pc[1:0];
  assign hi_bits      = |(fetch_pc >> (AW + 2));
  assign out_of_range = hi_bits || ({1'b0, fetch_idx} >= prog_len);
  assign fault_nxt    = (state != ST_RUN) || misaligned || out_of_range;
  assign rd_en        = fetch_req && !stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (!stall) begin
      valid_q <= fetch_req;
      fault_q <= fetch_req && fault_nxt;
    end
  end

  // RAM data is never reset, so it is masked unless a clean fetch is being presented.
  assign fetch_valid = valid_q;
  assign fetch_fault = fault_q;
  assign fetch_instr = (valid_q && !fault_q) ? ram_rdata : NOP_W;

  imem_sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_idx[AW-1:0]),
    .wdata (ld_data),
    .re    (rd_en),
    .raddr (fetch_idx),
    .rdata (ram_rdata)
  );

endmodule
